// File: rtl/seq_det_sched_if.sv
// Control/status bundle between a pass requester and the "1100" scan engine.
// The requester drives start/abort/data_in; the engine returns status and detector taps.
interface seq_det_sched_if #(
    parameter int W = 16
) ();
    logic         start;
    logic         abort;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;
    logic [7:0]   match_count;
    logic         bit_out;
    logic         z;

    modport master (
        output start, abort, data_in,
        input  busy, done, match_count, bit_out, z
    );

    modport slave (
        input  start, abort, data_in,
        output busy, done, match_count, bit_out, z
    );
endinterface

// File: rtl/seq_det_sched.sv
// Serialises a W-bit word MSB first through an overlapping "1100" Moore detector and counts hits.
// done pulses W+1 edges after start is accepted; start is ignored while busy, abort cancels a pass.
module seq_det_sched #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    seq_det_sched_if.slave bus
);
    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} ctrl_e;
    typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_e;

    ctrl_e         state_q, state_d;
    det_e          det_q, det_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    count_q, count_d;
    logic          in_pass;

    function automatic det_e det_step(input det_e s, input logic b);
        det_e n;
        case (s)
            S0:      n = b ? S1 : S0;
            S1:      n = b ? S2 : S0;
            S2:      n = b ? S2 : S3;
            S3:      n = b ? S1 : S4;
            S4:      n = b ? S1 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

    assign in_pass = (state_q == SHIFT) || (state_q == FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            det_q   <= S0;
            shreg_q <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        count_d = count_q;

        // The S4 state is counted one edge after it is entered, so the last bit's hit lands in FLUSH.
        if (in_pass && det_q == S4 && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end

        unique case (state_q)
            IDLE, DONE: begin
                det_d = S0;
                if (bus.start) begin
                    state_d = SHIFT;
                    shreg_d = bus.data_in;
                    cnt_d   = '0;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                det_d   = det_step(det_q, shreg_q[W-1]);
                shreg_d = {shreg_q[W-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = DONE;
                det_d   = S0;
            end
        endcase

        if (in_pass && bus.abort) begin
            state_d = IDLE;
            det_d   = S0;
            shreg_d = '0;
            cnt_d   = '0;
            count_d = '0;
        end
    end

    assign bus.busy        = in_pass;
    assign bus.done        = (state_q == DONE);
    assign bus.match_count = count_q;
    assign bus.bit_out     = (state_q == SHIFT) & shreg_q[W-1];
    assign bus.z           = (det_q == S4);
endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched (W=16): expected counts queued at start, popped on done.
module tb_seq_det_sched;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_det_sched_if #(.W(W)) bus ();
    seq_det_sched #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Independent reference: count every "1100" substring in the MSB-first bit string.
    function automatic logic [7:0] ref_count(input logic [15:0] w);
        logic [7:0] c = 8'd0;
        for (int i = 15; i >= 3; i--) begin
            if (w[i -: 4] == 4'b1100) c++;
        end
        return c;
    endfunction

    task automatic drive_start(input logic [15:0] w, input bit push, input logic [7:0] exp,
                               input bit with_abort);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.abort   = with_abort;
        bus.data_in = w;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    // ev_code: 1 = start pulse with another word, 2 = abort, 3 = reset (applied at sample ev_k).
    task automatic watch(input string name, input bit expect_done, input int ev_k, input int ev_code,
                         output int done_k, output int busy_n, output logic [63:0] z_mask,
                         output logic [15:0] bits);
        done_k = -1;
        busy_n = 0;
        z_mask = '0;
        bits   = '0;
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.z) z_mask[k] = 1'b1;
            if (k < 16) bits[15-k] = bus.bit_out;
            if (k == 16 && expect_done) check_eq({name, "_bitout_flush"}, bus.bit_out, 0);
            if (bus.done && done_k < 0) begin
                done_k = k;
                if (!expect_done) check_eq({name, "_no_done"}, 1, 0);
                else if (exp_q.size() == 0) check_eq({name, "_unexpected_done"}, 1, 0);
                else check_eq({name, "_count"}, bus.match_count, exp_q.pop_front());
            end
            if (done_k >= 0 && k == done_k + 1) begin
                check_eq({name, "_done_width"}, bus.done, 0);
                break;
            end
            if (k == ev_k + 1) begin
                if (ev_code == 2) begin
                    check_eq({name, "_abort_busy"}, bus.busy, 0);
                    check_eq({name, "_abort_count"}, bus.match_count, 0);
                    check_eq({name, "_abort_z"}, bus.z, 0);
                end
                if (ev_code == 3) begin
                    check_eq({name, "_rst_outs"},
                             {bus.busy, bus.done, bus.match_count, bus.bit_out, bus.z}, 0);
                end
                bus.start = 1'b0;
                bus.abort = 1'b0;
                reset     = 1'b0;
            end
            if (k == ev_k) begin
                case (ev_code)
                    1: begin bus.start = 1'b1; bus.data_in = 16'hFFFF; end
                    2: bus.abort = 1'b1;
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
        end
        if (expect_done && done_k < 0) check_eq({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic full_pass(input string name, input logic [15:0] w, input logic [7:0] exp,
                             input bit with_abort);
        int          dk, bn;
        logic [63:0] zm;
        logic [15:0] bits;
        drive_start(w, 1'b1, exp, with_abort);
        watch(name, 1'b1, -5, 0, dk, bn, zm, bits);
        check_eq({name, "_done_edge"}, dk, 17);
        check_eq({name, "_busy_cycles"}, bn, 17);
        check_eq({name, "_serial_bits"}, bits, w);
    endtask

    initial begin : main
        int          dk, bn, d1, d2;
        logic [63:0] zm;
        logic [15:0] bits, w;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", {bus.busy, bus.done, bus.match_count, bus.bit_out, bus.z}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        full_pass("cccc", 16'hCCCC, 8'd4, 1'b0);
        full_pass("3333", 16'h3333, 8'd3, 1'b0);
        full_pass("ffff", 16'hFFFF, 8'd0, 1'b0);
        full_pass("cc00", 16'hCC00, 8'd2, 1'b0);

        drive_start(16'h000C, 1'b1, 8'd1, 1'b0);
        watch("trail", 1'b1, -5, 0, dk, bn, zm, bits);
        check_eq("trail_done_edge", dk, 17);
        check_eq("trail_z_only_flush", zm, 64'h1 << 16);

        drive_start(16'hCC00, 1'b1, 8'd2, 1'b0);
        watch("start_ign", 1'b1, 6, 1, dk, bn, zm, bits);
        check_eq("start_ign_done_edge", dk, 17);
        check_eq("start_ign_bits", bits, 16'hCC00);

        drive_start(16'hCCCC, 1'b0, 8'd0, 1'b0);
        watch("abort", 1'b0, 8, 2, dk, bn, zm, bits);

        drive_start(16'hCCCC, 1'b0, 8'd0, 1'b0);
        watch("rst_mid", 1'b0, 5, 3, dk, bn, zm, bits);

        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            full_pass($sformatf("rand%0d", i), w, ref_count(w), i[0]);
        end

        // Back-to-back: start stays high through DONE, new word accepted without an IDLE cycle.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'hFFFF;
        exp_q.push_back(8'd0);
        @(posedge clk);
        #1;
        bus.data_in = 16'hCCCC;
        exp_q.push_back(8'd4);
        d1 = -1;
        d2 = -1;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (exp_q.size() == 0) check_eq("b2b_extra_done", 1, 0);
                else check_eq("b2b_count", bus.match_count, exp_q.pop_front());
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (d1 >= 0 && k == d1 + 1) begin
                check_eq("b2b_no_idle", {bus.busy, bus.done}, 2'b10);
                check_eq("b2b_count_cleared", bus.match_count, 0);
                bus.start = 1'b0;
            end
            if (d2 >= 0 && k == d2 + 1) break;
        end
        check_eq("b2b_first_done", d1, 17);
        check_eq("b2b_gap", d2 - d1, 18);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end
endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter: W, default 16, serial word length in bits; legal range 4..64.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to load data_in and run one detection pass.
REQ-005 Port: abort  input  1  cancel an in-progress pass.
REQ-006 Port: data_in  input  W  word to scan; bit W-1 is presented first.
REQ-007 Port: busy  output  1  high while a pass is in progress (SHIFT or FLUSH).
REQ-008 Port: done  output  1  one-cycle pulse; match_count is final.
REQ-009 Port: match_count  output  8  number of "1100" detections in the last pass.
REQ-010 Port: bit_out  output  1  serial bit currently fed to the detector.
REQ-011 Port: z  output  1  Moore detector output; high only in detector state S4.

Function
REQ-012 Controller FSM states SHALL be IDLE, SHIFT, FLUSH and DONE.
REQ-013 IDLE: start=1 SHALL capture data_in into shift register, clear bit counter and match_count, force detector to S0, and move to SHIFT.
REQ-014 SHIFT: bit_out SHALL equal shift-register bit W-1. At each edge, the detector SHALL advance on bit_out and the register SHALL shift left by one.
REQ-015 SHIFT SHALL last exactly W cycles, then move to FLUSH.
REQ-016 FLUSH SHALL last exactly 1 cycle with the detector held. This lets the detection caused by the last bit be counted.
REQ-017 DONE SHALL last 1 cycle with done=1, then move to IDLE. If start=1 in DONE, it SHALL instead accept the new word exactly as in IDLE.
REQ-018 done SHALL rise on the (W+1)th rising edge after the edge that accepted start (edge 17 for W=16).
REQ-019 Detector states SHALL be: S0 (none), S1 ("1"), S2 ("11"), S3 ("110"), S4 ("1100" detected).
REQ-020 Detector transitions on bit b SHALL be:
- S0: b=1 goes to S1, else S0.
- S1: b=1 goes to S2, else S0.
- S2: b=0 goes to S3, else S2.
- S3: b=0 goes to S4, else S1.
- S4: b=1 goes to S1, else S0.
Detection is overlapping.
REQ-021 z SHALL be 1 exactly when the detector is in S4, and 0 otherwise.
REQ-022 The detector SHALL advance only in SHIFT. It SHALL hold in FLUSH. It SHALL be forced to S0 on entry to DONE and whenever in IDLE.
REQ-023 match_count SHALL increment by 1 on each edge in SHIFT or FLUSH where the detector is in S4. It SHALL saturate at 255.
REQ-024 match_count SHALL hold its final value from DONE until the next accepted start.
REQ-025 busy SHALL be 1 in SHIFT and FLUSH, and 0 in IDLE and DONE.
REQ-026 start while busy=1 SHALL be ignored, with no effect on data, count or timing.
REQ-027 abort=1 in SHIFT or FLUSH SHALL move to IDLE at the next edge. It SHALL clear match_count, force the detector to S0, and produce no done pulse.
REQ-028 abort SHALL be ignored in IDLE and DONE. If abort and start are both asserted in IDLE or DONE, start SHALL win.
REQ-029 bit_out SHALL be 0 outside SHIFT.

Reset
REQ-030 reset=1 at a rising edge SHALL put the block in IDLE, in any state including mid-pass. It SHALL set detector S0, busy=0, done=0, match_count=0, bit_out=0, z=0, and clear the shift register and bit counter.
REQ-031 reset SHALL take priority over start and abort.

Verification
REQ-032 W=16, start with data_in=16'hCCCC -> done pulses at edge 17 after acceptance, match_count=4, busy high for 17 cycles.
REQ-033 data_in=16'h3333 -> match_count=3; data_in=16'hFFFF -> match_count=0; data_in=16'hCC00 -> match_count=2.
REQ-034 Trailing match: data_in=16'h000C -> match_count=1, counted during FLUSH; z=1 only in the FLUSH cycle.
REQ-035 Back-to-back: start held high through DONE with a new word 16'hCCCC -> second pass begins with no IDLE cycle; match_count cleared, then final value 4.
REQ-036 Mid-pass events:
- start pulsed during SHIFT -> ignored.
- abort at bit 8 -> IDLE next edge, match_count=0, no done.
- reset at bit 5 of a new pass -> all outputs 0 at next edge.
